// File: rtl/uart_word_tx_arbiter_if.sv
// FIFO-side and serialiser-side signals of the UART word TX arbiter.
// master = arbiter, slave = FIFOs and serialiser.
interface uart_word_tx_arbiter_if;
    logic        i_ch0_fifo_empty;
    logic [31:0] i_ch0_fifo_data;
    logic        o_ch0_fifo_rd_en;
    logic        i_ch1_fifo_empty;
    logic [31:0] i_ch1_fifo_data;
    logic        o_ch1_fifo_rd_en;
    logic        i_serial_is_busy;
    logic        o_serial_next_word_cmd;
    logic [31:0] o_serial_word_data;

    modport master (
        input  i_ch0_fifo_empty,
        input  i_ch0_fifo_data,
        output o_ch0_fifo_rd_en,
        input  i_ch1_fifo_empty,
        input  i_ch1_fifo_data,
        output o_ch1_fifo_rd_en,
        input  i_serial_is_busy,
        output o_serial_next_word_cmd,
        output o_serial_word_data
    );

    modport slave (
        output i_ch0_fifo_empty,
        output i_ch0_fifo_data,
        input  o_ch0_fifo_rd_en,
        output i_ch1_fifo_empty,
        output i_ch1_fifo_data,
        input  o_ch1_fifo_rd_en,
        output i_serial_is_busy,
        input  o_serial_next_word_cmd,
        input  o_serial_word_data
    );
endinterface

// File: rtl/uart_word_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit word serialiser between two TX FIFOs.
// Define UART_TX_WATCHDOG_EN to abort transfers whose busy phase exceeds WATCHDOG_CYCLES.
module uart_word_tx_arbiter #(
    parameter int unsigned WATCHDOG_CYCLES = 4096,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    uart_word_tx_arbiter_if.master bus,
    output logic                   o_active_channel,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_words_sent_count,
    output logic                   o_watchdog_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LATCH     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   active_q, active_d;
    logic                   ch0_rd_q, ch0_rd_d;
    logic                   ch1_rd_q, ch1_rd_d;
    logic                   cmd_q, cmd_d;
    logic [31:0]            word_q, word_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   req0_s, req1_s, grant_ch_s;

`ifdef UART_TX_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);
    logic [15:0]            wd_cnt_q, wd_cnt_d;
    logic                   wd_err_q, wd_err_d;
`endif

    assign req0_s = ~bus.i_ch0_fifo_empty;
    assign req1_s = ~bus.i_ch1_fifo_empty;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        active_d     = active_q;
        ch0_rd_d     = 1'b0;
        ch1_rd_d     = 1'b0;
        cmd_d        = 1'b0;
        word_d       = word_q;
        count_d      = count_q;
        grant_ch_s   = 1'b0;
`ifdef UART_TX_WATCHDOG_EN
        wd_cnt_d     = 16'd0;
        wd_err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_enable && (req0_s || req1_s)) begin
                    // Contention goes to whichever channel did not win last time
                    if (req0_s && req1_s) begin
                        grant_ch_s = ~last_grant_q;
                    end else begin
                        grant_ch_s = req1_s;
                    end
                    active_d = grant_ch_s;
                    ch0_rd_d = ~grant_ch_s;
                    ch1_rd_d = grant_ch_s;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (active_q) begin
                    word_d = bus.i_ch1_fifo_data;
                end else begin
                    word_d = bus.i_ch0_fifo_data;
                end
                cmd_d   = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.i_serial_is_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i_serial_is_busy) begin
                    count_d      = count_q + COUNT_WIDTH'(1);
                    last_grant_d = active_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART_TX_WATCHDOG_EN
        // A normal completion on the limit cycle wins over the abort
        if ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) begin
            if ((state_d != ST_IDLE) && (wd_cnt_q == WD_LAST)) begin
                state_d      = ST_IDLE;
                wd_err_d     = 1'b1;
                last_grant_d = active_q;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end else begin
            wd_cnt_d = 16'd0;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            active_q     <= 1'b0;
            ch0_rd_q     <= 1'b0;
            ch1_rd_q     <= 1'b0;
            cmd_q        <= 1'b0;
            word_q       <= 32'd0;
            busy_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            active_q     <= active_d;
            ch0_rd_q     <= ch0_rd_d;
            ch1_rd_q     <= ch1_rd_d;
            cmd_q        <= cmd_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

`ifdef UART_TX_WATCHDOG_EN
    // Watchdog counter and abort pulse registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_cnt_q <= 16'd0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign o_watchdog_err = wd_err_q;
`else
    assign o_watchdog_err = 1'b0;
`endif

    assign bus.o_ch0_fifo_rd_en       = ch0_rd_q;
    assign bus.o_ch1_fifo_rd_en       = ch1_rd_q;
    assign bus.o_serial_next_word_cmd = cmd_q;
    assign bus.o_serial_word_data     = word_q;
    assign o_active_channel           = active_q;
    assign o_busy                     = busy_q;
    assign o_words_sent_count         = count_q;

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// Self-checking bench: FIFO and serialiser models plus a round-robin reference model.
module tb_uart_word_tx_arbiter;

    logic        i_clock   = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_enable  = 1'b0;
    logic        o_active_channel;
    logic        o_busy;
    logic [15:0] o_words_sent_count;
    logic        o_watchdog_err;

    uart_word_tx_arbiter_if bus();

    uart_word_tx_arbiter #(
        .WATCHDOG_CYCLES (16),
        .COUNT_WIDTH     (16)
    ) dut (
        .i_clock            (i_clock),
        .i_reset_n          (i_reset_n),
        .i_enable           (i_enable),
        .bus                (bus),
        .o_active_channel   (o_active_channel),
        .o_busy             (o_busy),
        .o_words_sent_count (o_words_sent_count),
        .o_watchdog_err     (o_watchdog_err)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // FIFO models: written by the stimulus, popped on sampled rd_en
    logic [31:0] f0_mem [0:255];
    logic [31:0] f1_mem [0:255];
    logic [7:0]  f0_wr = 8'd0, f0_rd = 8'd0, f1_wr = 8'd0, f1_rd = 8'd0;
    logic [31:0] f0_data = 32'd0, f1_data = 32'd0;

    assign bus.i_ch0_fifo_empty = (f0_rd == f0_wr);
    assign bus.i_ch1_fifo_empty = (f1_rd == f1_wr);
    assign bus.i_ch0_fifo_data  = f0_data;
    assign bus.i_ch1_fifo_data  = f1_data;

    // Serialiser model: busy for busy_len cycles after each start pulse
    int          busy_len  = 4;
    bit          ser_stuck = 1'b0;
    int          ser_left  = 0;
    logic        ser_busy  = 1'b0;
    logic [31:0] log_w[$];
    logic        log_c[$];
    assign bus.i_serial_is_busy = ser_busy;

    // Event monitor counters
    int rd0_n = 0, rd1_n = 0, cmd_n = 0, err_n = 0;
    int rd_cyc = 0, cmd_cyc = 0, err_cyc = 0;

    // Reference model state
    logic [31:0] m0[$];
    logic [31:0] m1[$];
    logic [31:0] exp_w[$];
    logic        exp_c[$];
    logic        model_last = 1'b1;
    logic [15:0] model_cnt  = 16'd0;
    int          log_base   = 0;

    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        if (bus.o_ch0_fifo_rd_en) begin
            rd0_n  <= rd0_n + 1;
            rd_cyc <= cyc;
            if (f0_rd != f0_wr) begin
                f0_data <= f0_mem[f0_rd];
                f0_rd   <= f0_rd + 8'd1;
            end
        end
        if (bus.o_ch1_fifo_rd_en) begin
            rd1_n  <= rd1_n + 1;
            rd_cyc <= cyc;
            if (f1_rd != f1_wr) begin
                f1_data <= f1_mem[f1_rd];
                f1_rd   <= f1_rd + 8'd1;
            end
        end
        if (bus.o_serial_next_word_cmd) begin
            cmd_n   <= cmd_n + 1;
            cmd_cyc <= cyc;
        end
        if (o_watchdog_err) begin
            err_n   <= err_n + 1;
            err_cyc <= cyc;
        end
    end

    always @(posedge i_clock) begin
        if (bus.o_serial_next_word_cmd) begin
            log_w.push_back(bus.o_serial_word_data);
            log_c.push_back(o_active_channel);
            ser_left <= busy_len;
            ser_busy <= 1'b1;
        end else if (ser_stuck) begin
            ser_busy <= 1'b1;
        end else if (ser_left > 1) begin
            ser_left <= ser_left - 1;
        end else begin
            ser_left <= 0;
            ser_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit ch, input logic [31:0] w, input bit to_model);
        if (ch) begin
            f1_mem[f1_wr] = w;
            f1_wr = f1_wr + 8'd1;
            if (to_model) m1.push_back(w);
        end else begin
            f0_mem[f0_wr] = w;
            f0_wr = f0_wr + 8'd1;
            if (to_model) m0.push_back(w);
        end
    endtask

    // All queued words are visible at once, so service order is pure round-robin
    task automatic model_drain();
        logic        ch;
        logic [31:0] w;
        while ((m0.size() > 0) || (m1.size() > 0)) begin
            if ((m0.size() > 0) && (m1.size() > 0)) ch = ~model_last;
            else ch = (m1.size() > 0);
            if (ch) w = m1.pop_front();
            else w = m0.pop_front();
            exp_w.push_back(w);
            exp_c.push_back(ch);
            model_last = ch;
            model_cnt  = model_cnt + 16'd1;
        end
    endtask

    task automatic compare_log(input string tag);
        check($sformatf("%s_nwords", tag), 64'(log_w.size() - log_base), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            if (log_base + i < log_w.size()) begin
                check($sformatf("%s_word%0d", tag, i), 64'(log_w[log_base + i]), 64'(exp_w[i]));
                check($sformatf("%s_chan%0d", tag, i), 64'(log_c[log_base + i]), 64'(exp_c[i]));
            end
        end
        log_base = log_w.size();
        exp_w.delete();
        exp_c.delete();
    endtask

    task automatic wait_done(input string tag, input logic [15:0] target);
        int n = 0;
        while (!((o_words_sent_count == target) && (o_busy == 1'b0)) && (n < 3000)) begin
            @(negedge i_clock);
            n++;
        end
        check($sformatf("%s_done_in_time", tag), 64'(n < 3000), 64'd1);
    endtask

    // sel: 0 start pulse, 1 serialiser busy, 2 serialiser idle, 3 watchdog error
    task automatic wait_for(input string tag, input int sel);
        int  n = 0;
        bit  hit = 1'b0;
        while (!hit && (n < 3000)) begin
            @(negedge i_clock);
            n++;
            case (sel)
                0: hit = bus.o_serial_next_word_cmd;
                1: hit = ser_busy;
                2: hit = !ser_busy;
                default: hit = o_watchdog_err;
            endcase
        end
        check($sformatf("%s_seen_in_time", tag), 64'(hit), 64'd1);
    endtask

    task automatic reset_dut();
        @(negedge i_clock);
        i_enable  = 1'b0;
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clock);
        i_reset_n  = 1'b1;
        model_last = 1'b1;
        model_cnt  = 16'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd0"},    64'(bus.o_ch0_fifo_rd_en),       64'd0);
        check({tag, "_rd1"},    64'(bus.o_ch1_fifo_rd_en),       64'd0);
        check({tag, "_cmd"},    64'(bus.o_serial_next_word_cmd), 64'd0);
        check({tag, "_word"},   64'(bus.o_serial_word_data),     64'd0);
        check({tag, "_active"}, 64'(o_active_channel),           64'd0);
        check({tag, "_busy"},   64'(o_busy),                     64'd0);
        check({tag, "_count"},  64'(o_words_sent_count),         64'd0);
        check({tag, "_wderr"},  64'(o_watchdog_err),             64'd0);
    endtask

    initial begin
        int b_rd0, b_rd1, b_cmd, b_err, n0, n1;

        repeat (3) @(negedge i_clock);
        check_reset_values("por");
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // Single word on ch0 with a long serialiser busy phase
        b_rd0 = rd0_n; b_rd1 = rd1_n; b_cmd = cmd_n;
        busy_len = 40;
        push(1'b0, 32'hDEADBEEF, 1'b1);
        model_drain();
        i_enable = 1'b1;
        wait_done("single", model_cnt);
        check("single_rd0_pulses", 64'(rd0_n - b_rd0), 64'd1);
        check("single_rd1_pulses", 64'(rd1_n - b_rd1), 64'd0);
        check("single_cmd_pulses", 64'(cmd_n - b_cmd), 64'd1);
        check("single_rd_to_cmd",  64'(cmd_cyc - rd_cyc), 64'd2);
        check("single_count",      64'(o_words_sent_count), 64'd1);
        compare_log("single");

        // Both channels loaded with three words each
        reset_dut();
        b_cmd = cmd_n;
        busy_len = int'($urandom_range(1, 6));
        for (int i = 0; i < 3; i++) begin
            push(1'b0, $urandom, 1'b1);
            push(1'b1, $urandom, 1'b1);
        end
        model_drain();
        i_enable = 1'b1;
        wait_done("rr6", model_cnt);
        check("rr6_cmd_pulses", 64'(cmd_n - b_cmd), 64'd6);
        check("rr6_count",      64'(o_words_sent_count), 64'd6);
        compare_log("rr6");

        // Random batches, arbitration state carried across batches
        for (int r = 0; r < 4; r++) begin
            @(negedge i_clock);
            busy_len = int'($urandom_range(1, 6));
            n0 = int'($urandom_range(0, 4));
            n1 = int'($urandom_range(0, 4));
            for (int i = 0; i < n0; i++) push(1'b0, $urandom, 1'b1);
            for (int i = 0; i < n1; i++) push(1'b1, $urandom, 1'b1);
            model_drain();
            wait_done($sformatf("rand%0d", r), model_cnt);
            check($sformatf("rand%0d_count", r), 64'(o_words_sent_count), 64'(model_cnt));
            compare_log($sformatf("rand%0d", r));
        end

        // Enable dropped while the first word is in flight
        reset_dut();
        b_rd0 = rd0_n;
        busy_len = 8;
        push(1'b0, $urandom, 1'b1);
        push(1'b0, $urandom, 1'b1);
        model_drain();
        i_enable = 1'b1;
        wait_for("endrop_busy", 1);
        i_enable = 1'b0;
        wait_done("endrop_first", 16'd1);
        repeat (20) @(negedge i_clock);
        check("endrop_rd0_held",  64'(rd0_n - b_rd0), 64'd1);
        check("endrop_count_held", 64'(o_words_sent_count), 64'd1);
        check("endrop_idle",       64'(o_busy), 64'd0);
        i_enable = 1'b1;
        wait_done("endrop_resume", model_cnt);
        check("endrop_rd0_total", 64'(rd0_n - b_rd0), 64'd2);
        compare_log("endrop");

        // Reset asserted while waiting for the serialiser to acknowledge
        busy_len = 10;
        push(1'b1, $urandom, 1'b0);
        wait_for("midrst_cmd", 0);
        @(posedge i_clock);
        #1;
        i_reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge i_clock);
        i_reset_n  = 1'b1;
        model_last = 1'b1;
        model_cnt  = 16'd0;
        wait_for("midrst_ser_idle", 2);
        log_base = log_w.size();
        push(1'b1, $urandom, 1'b1);
        push(1'b0, $urandom, 1'b1);
        model_drain();
        wait_done("midrst_after", model_cnt);
        compare_log("midrst");

        // Sent-word counter wraps from all-ones to zero
        @(negedge i_clock);
        force dut.count_q = 16'hFFFF;
        @(negedge i_clock);
        release dut.count_q;
        @(negedge i_clock);
        check("wrap_preload", 64'(o_words_sent_count), 64'hFFFF);
        model_cnt = 16'hFFFF;
        busy_len  = 3;
        push(1'b0, $urandom, 1'b1);
        model_drain();
        wait_done("wrap", model_cnt);
        check("wrap_count", 64'(o_words_sent_count), 64'd0);
        compare_log("wrap");

`ifdef UART_TX_WATCHDOG_EN
        // Serialiser stuck busy: abort after 16 cycles in the wait states
        reset_dut();
        wait_for("wd_ser_idle", 2);
        log_base = log_w.size();
        b_err = err_n;
        ser_stuck = 1'b1;
        push(1'b0, $urandom, 1'b0);
        i_enable = 1'b1;
        wait_for("wd_err", 3);
        repeat (4) @(negedge i_clock);
        check("wd_err_pulses",   64'(err_n - b_err), 64'd1);
        check("wd_err_latency",  64'(err_cyc - cmd_cyc), 64'd17);
        check("wd_count_kept",   64'(o_words_sent_count), 64'd0);
        check("wd_idle",         64'(o_busy), 64'd0);
        ser_stuck = 1'b0;
        wait_for("wd_ser_release", 2);
        log_base   = log_w.size();
        model_last = 1'b0;
        push(1'b0, $urandom, 1'b1);
        push(1'b1, $urandom, 1'b1);
        model_drain();
        wait_done("wd_after", model_cnt);
        compare_log("wd_after");
`else
        b_err = 0;
        check("wd_never_pulses", 64'(err_n - b_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
